// File: rtl/data_compare_serial.sv
// data_compare_serial: multi-cycle magnitude comparator for wide operands.
// Walks two 4*NIBBLES-bit words one nibble per clock and produces a one-hot
// {gt, lt, eq} result. The cascade-in supplies the lower-significance result
// and decides when every nibble is equal.
//
// Optional feature macro: DATA_COMPARE_SERIAL_EARLY_EXIT_EN
//   undefined : LSB-first traversal, fixed latency NIBBLES+1
//   defined   : MSB-first traversal, finishes on the first unequal nibble
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for a start
// RUN    | one nibble compared per cycle, oBusy=1
// DONE   | one cycle, oDone=1, oData newly valid; may accept a new start

module data_compare_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    input  logic [4*NIBBLES-1:0] iData_a,
    input  logic [4*NIBBLES-1:0] iData_b,
    input  logic [2:0]           iData,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2:0]           oData
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [2:0]    res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [2:0]    data_q, data_d;

    int            nib_idx;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;

    // Anything other than a clean gt or lt falls back to "equal".
    function automatic logic [2:0] sanitize(input logic [2:0] c);
        case (c)
            3'b100, 3'b010: return c;
            default:        return 3'b001;
        endcase
    endfunction

    // Select the nibble pair addressed by the counter for the current traversal order.
    always_comb begin
`ifdef DATA_COMPARE_SERIAL_EARLY_EXIT_EN
        nib_idx = NIBBLES - 1 - int'(cnt_q);
`else
        nib_idx = int'(cnt_q);
`endif
        nib_a = a_q[nib_idx*4 +: 4];
        nib_b = b_q[nib_idx*4 +: 4];
    end

    // Next-state logic: start capture, per-nibble result update, and output staging.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    a_d     = iData_a;
                    b_d     = iData_b;
                    res_d   = sanitize(iData);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (nib_a > nib_b) begin
                    res_d = 3'b100;
                end else if (nib_a < nib_b) begin
                    res_d = 3'b010;
                end
`ifdef DATA_COMPARE_SERIAL_EARLY_EXIT_EN
                // MSB-first: the first unequal nibble already decides.
                if ((nib_a != nib_b) || (cnt_q == LAST)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are staged from the next state so they are registered and aligned with it.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
        data_d = done_d ? res_d : data_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= 3'b001;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 3'b001;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oData = data_q;

endmodule

// File: tb/tb_data_compare_serial.sv
// Testbench for data_compare_serial (NIBBLES=4). Expected results and latencies
// come from a word-level model; build with or without
// DATA_COMPARE_SERIAL_EARLY_EXIT_EN to match the RTL build.

module tb_data_compare_serial;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iStart = 1'b0;
    logic [W-1:0] iData_a = '0;
    logic [W-1:0] iData_b = '0;
    logic [2:0]   iData = 3'b000;
    logic         oBusy;
    logic         oDone;
    logic [2:0]   oData;

    int checks = 0;
    int errors = 0;

    data_compare_serial #(.NIBBLES(N)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData)
    );

    always #5 iClk = ~iClk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] c);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        if (c == 3'b100 || c == 3'b010) return c;
        return 3'b001;
    endfunction

    function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DATA_COMPARE_SERIAL_EARLY_EXIT_EN
        for (int m = 0; m < N; m++) begin
            if (a[(N-1-m)*4 +: 4] != b[(N-1-m)*4 +: 4]) return m + 2;
        end
`endif
        return N + 1;
    endfunction

    // Issues a start (caller is just after a rising edge, DUT in IDLE or DONE),
    // scrambles the operand inputs afterwards, and measures cycle of oDone.
    task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                               output int lat, output logic [2:0] res, output bit busy_bad);
        iData_a = a;
        iData_b = b;
        iData   = c;
        iStart  = 1'b1;
        @(posedge iClk); #1;
        iStart  = 1'b0;
        iData_a = W'($urandom);
        iData_b = W'($urandom);
        iData   = 3'($urandom);
        lat      = -1;
        res      = 3'bxxx;
        busy_bad = 1'b0;
        for (int n = 1; n <= 3 * N + 10; n++) begin
            if (oDone === 1'b1) begin
                lat = n;
                res = oData;
                if (oBusy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (oBusy !== 1'b1) busy_bad = 1'b1;
            @(posedge iClk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iRst = 1'b1;
        iStart = 1'b1;
        iData_a = 16'h0001;
        iData_b = 16'h0002;
        iData = 3'b100;
        idle_cycles(2);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", oBusy); end
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", oDone); end
        checks++; if (oData !== 3'b001) begin errors++; $display("FAIL reset_data got %b want 001", oData); end
        iRst = 1'b0;
        iStart = 1'b0;
        idle_cycles(1);
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy got %b want 0", oBusy); end
    endtask

    task automatic test_equal_cascade();
        int lat; logic [2:0] res; bit bb;
        run_compare(16'h1234, 16'h1234, 3'b100, lat, res, bb);
        checks++; if (res !== 3'b100) begin errors++; $display("FAIL eq_casc_gt_data got %b want 100", res); end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL eq_casc_gt_lat got %0d want %0d", lat, N + 1); end
        checks++; if (bb) begin errors++; $display("FAIL eq_casc_gt_busy got bad want clean"); end
        idle_cycles(1);
        run_compare(16'h1234, 16'h1234, 3'b110, lat, res, bb);
        checks++; if (res !== 3'b001) begin errors++; $display("FAIL eq_casc_110_data got %b want 001", res); end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL eq_casc_110_lat got %0d want %0d", lat, N + 1); end
        idle_cycles(1);
    endtask

    task automatic test_gt_msb();
        int lat; logic [2:0] res; bit bb;
        run_compare(16'hA000, 16'h9FFF, 3'b010, lat, res, bb);
        checks++; if (res !== 3'b100) begin errors++; $display("FAIL gt_msb_data got %b want 100", res); end
        checks++; if (lat != model_lat(16'hA000, 16'h9FFF)) begin
            errors++; $display("FAIL gt_msb_lat got %0d want %0d", lat, model_lat(16'hA000, 16'h9FFF)); end
        checks++; if (bb) begin errors++; $display("FAIL gt_msb_busy got bad want clean"); end
        idle_cycles(1);
        checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", oDone); end
        idle_cycles(2);
        checks++; if (oData !== 3'b100) begin errors++; $display("FAIL data_hold got %b want 100", oData); end
    endtask

    task automatic test_lt_lsb();
        int lat; logic [2:0] res; bit bb;
        run_compare(16'h0001, 16'h0002, 3'b100, lat, res, bb);
        checks++; if (res !== 3'b010) begin errors++; $display("FAIL lt_lsb_data got %b want 010", res); end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL lt_lsb_lat got %0d want %0d", lat, N + 1); end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        int lat; logic [2:0] res; bit bb;
        lat = -1;
        iData_a = 16'h0005;
        iData_b = 16'h0003;
        iData = 3'b001;
        iStart = 1'b1;
        @(posedge iClk); #1;                 // cycle 1
        iStart = 1'b0;
        idle_cycles(1);                      // cycle 2
        iStart = 1'b1;
        iData_a = 16'h0000;
        iData_b = 16'hFFFF;
        iData = 3'b100;
        idle_cycles(1);                      // cycle 3
        idle_cycles(1);                      // cycle 4
        iStart = 1'b0;
        for (int n = 4; n <= 3 * N + 10; n++) begin
            if (oDone === 1'b1) begin lat = n; break; end
            @(posedge iClk); #1;
        end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL ignore_start_lat got %0d want %0d", lat, N + 1); end
        checks++; if (oData !== 3'b100) begin errors++; $display("FAIL ignore_start_data got %b want 100", oData); end
        // Start in the DONE cycle.
        run_compare(16'h0000, 16'hFFFF, 3'b100, lat, res, bb);
        checks++; if (res !== 3'b010) begin errors++; $display("FAIL b2b_data got %b want 010", res); end
        checks++; if (lat != model_lat(16'h0000, 16'hFFFF)) begin
            errors++; $display("FAIL b2b_lat got %0d want %0d", lat, model_lat(16'h0000, 16'hFFFF)); end
        checks++; if (bb) begin errors++; $display("FAIL b2b_busy got bad want clean"); end
        idle_cycles(1);
    endtask

    task automatic test_reset_abort();
        int lat; logic [2:0] res; bit bb; bit saw_done;
        run_compare(16'hA000, 16'h9FFF, 3'b001, lat, res, bb);
        idle_cycles(2);
        iData_a = 16'h0001;
        iData_b = 16'h0002;
        iData = 3'b100;
        iStart = 1'b1;
        @(posedge iClk); #1;                 // cycle 1
        iStart = 1'b0;
        idle_cycles(2);                      // cycle 3
        iRst = 1'b1;
        idle_cycles(1);
        iRst = 1'b0;
        checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", oBusy); end
        checks++; if (oData !== 3'b001) begin errors++; $display("FAIL abort_data got %b want 001", oData); end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (oDone !== 1'b0 || oBusy !== 1'b0) saw_done = 1'b1;
            @(posedge iClk); #1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done got activity want none"); end
        run_compare(16'h0001, 16'h0002, 3'b100, lat, res, bb);
        checks++; if (res !== 3'b010) begin errors++; $display("FAIL post_abort_data got %b want 010", res); end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL post_abort_lat got %0d want %0d", lat, N + 1); end
        idle_cycles(1);
    endtask

    task automatic test_random();
        int lat; logic [2:0] res; bit bb;
        logic [W-1:0] a, b; logic [2:0] c;
        int bad_res, bad_lat, bad_hot, bad_busy;
        bad_res = 0; bad_lat = 0; bad_hot = 0; bad_busy = 0;
        for (int it = 0; it < 1000; it++) begin
            a = W'($urandom);
            b = a;
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) b[k*4 +: 4] = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) b = W'($urandom);
            c = 3'($urandom_range(0, 7));
            run_compare(a, b, c, lat, res, bb);
            checks++; if (res !== model_res(a, b, c)) begin
                errors++; bad_res++;
                if (bad_res <= 5) $display("FAIL rand_data a=%h b=%h c=%b got %b want %b", a, b, c, res, model_res(a, b, c)); end
            checks++; if (lat != model_lat(a, b)) begin
                errors++; bad_lat++;
                if (bad_lat <= 5) $display("FAIL rand_lat a=%h b=%h got %0d want %0d", a, b, lat, model_lat(a, b)); end
            checks++; if (!$onehot(res)) begin
                errors++; bad_hot++;
                if (bad_hot <= 5) $display("FAIL rand_onehot got %b want one-hot", res); end
            checks++; if (bb) begin
                errors++; bad_busy++;
                if (bad_busy <= 5) $display("FAIL rand_busy a=%h b=%h got bad want clean", a, b); end
            // Mix starts from DONE with starts from IDLE.
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_equal_cascade();
        test_gt_msb();
        test_lt_lsb();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
